leb128_decoder: RTL and testbench
=================================

// Module: leb128_decoder
// PURPOSE
//  Upstream immediate-fetch stage of the WebAssembly CPU. On start it walks bytecode ROM from a
//  byte address and decodes one LEB128 immediate (u32/u64/s32/s64) for i32/i64.const, br, local.get
//  and similar opcodes. The value, the address of the following byte and a trap code feed the
//  operand stack/execute stage.
//  - ROM model: registered read. rom_data in cycle k+1 holds the byte at rom_addr in cycle k.
// PARAMETERS
//  ROM_ADDR  4  byte-address width of the bytecode ROM
// PORTS
//  clk         in   1         system clock, rising edge
//  reset       in   1         synchronous, active-high
//  start       in   1         begin decode; accepted only in IDLE
//  pc_in       in   ROM_ADDR  address of first LEB128 byte
//  signed_mode in   1         1 = sLEB128 (sign-extend), 0 = uLEB128
//  is_64       in   1         1 = 64-bit immediate (max 10 bytes), 0 = 32-bit (max 5 bytes)
//  rom_addr    out  ROM_ADDR  byte address to ROM (registered)
//  rom_data    in   8         ROM read data
//  busy        out  1         high from the cycle after start until done
//  done        out  1         one-cycle pulse: value/next_pc/trap valid
//  value       out  64        decoded immediate
//  next_pc     out  ROM_ADDR  address of the byte after the last LEB128 byte
//  trap        out  3         0 = none, 3'd5 = malformed/overlong immediate
// BEHAVIOUR
//  - Reset: state IDLE; rom_addr, value, next_pc, trap = 0; busy = done = 0.
//  - FSM states:
//    - IDLE: on start, latch signed_mode/is_64, rom_addr <= pc_in, count <= 0, acc <= 0, shift <= 0
//      -> WAIT.
//    - WAIT: one ROM-latency cycle; rom_addr <= rom_addr+1 -> ACCUM.
//    - ACCUM: each cycle consume rom_data: acc |= (rom_data[6:0] << shift); shift += 7;
//      count += 1; rom_addr += 1.
//      - If rom_data[7] == 0 -> DONE.
//      - If rom_data[7] == 1 and count+1 == max bytes (5 or 10) -> DONE with trap = 5.
//    - DONE: done = 1 for exactly one cycle -> IDLE.
//  - Latency: an N-byte immediate with start sampled at edge E0 gives done high in the cycle after
//    edge E0+N+1. busy is high from E0 through the edge that raises done; busy = 0 while done = 1.
//  - Sign extension: if signed_mode, the terminating byte has bit6 = 1, and shift < 64, then
//    value bits [63:shift] = 1.
//    - 32-bit signed results are sign-extended to 64 bits.
//    - 32-bit unsigned results have [63:32] = 0.
//  - Unused high bits of the final byte are ignored; bits shifted past bit 63 are dropped. Only
//    continuation overrun traps.
//  - next_pc = pc_in + N. On trap: next_pc = pc_in + max bytes, value = 0.
//  - value, next_pc and trap hold their last result until the next accepted start.
//  - start while not IDLE is ignored, with no effect on the decode in progress.
//  - rom_addr wraps modulo 2^ROM_ADDR without error.
//  - Reset mid-decode aborts at the next edge: IDLE and all outputs as at reset; done never pulses.
// TESTING
//  1. ROM[0]=0x05, start pc_in=0, unsigned 32 -> done 2 cycles after start edge, value=5, next_pc=1, trap=0.
//  2. ROM[2..4]=E5 8E 26, unsigned 64 -> value=624485 (0x98765), next_pc=5, done 4 cycles after start.
//  3. ROM[0]=0x7F, signed 64 -> value=64'hFFFF_FFFF_FFFF_FFFF; ROM C0 BB 78, signed -> value=-123456.
//  4. Five bytes 0x80 then 0x80, 32-bit -> trap=5, value=0, next_pc=pc_in+5; same bytes in 64-bit mode with
//     a 6th byte 0x01 -> value=1<<35, trap=0.
//  5. Start with 3-byte immediate, assert reset 1 cycle after start -> busy=0, done never pulses,
//     rom_addr=0; a fresh start then decodes correctly.
//  6. Start pulsed again while busy -> ignored; result equals the first decode; back-to-back starts
//     after done both succeed.

Source files
------------

// File: rtl/leb128_decoder_if.sv
// Request/response and ROM-port bundle between the fetch controller and the LEB128 decoder.
interface leb128_decoder_if #(
  parameter int ROM_ADDR = 4
);
  logic                start;
  logic [ROM_ADDR-1:0] pc_in;
  logic                signed_mode;
  logic                is_64;
  logic [ROM_ADDR-1:0] rom_addr;
  logic [7:0]          rom_data;
  logic                busy;
  logic                done;
  logic [63:0]         value;
  logic [ROM_ADDR-1:0] next_pc;
  logic [2:0]          trap;

  modport master (
    output start, pc_in, signed_mode, is_64, rom_data,
    input  rom_addr, busy, done, value, next_pc, trap
  );

  modport slave (
    input  start, pc_in, signed_mode, is_64, rom_data,
    output rom_addr, busy, done, value, next_pc, trap
  );
endinterface

// File: rtl/leb128_decoder.sv
// Immediate-fetch stage: walks bytecode ROM from pc_in and decodes one u/s LEB128 immediate
// (32 or 64 bit), reporting value, the following byte address and an overrun trap.
module leb128_decoder #(
  parameter int ROM_ADDR = 4
) (
  input  logic               clk,
  input  logic               reset,
  leb128_decoder_if.slave    bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCUM, S_DONE} state_t;

  localparam logic [2:0] TRAP_MALFORMED = 3'd5;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ROM_ADDR-1:0] r_addr;
  logic [ROM_ADDR-1:0] r_pc;
  logic                r_signed;
  logic                r_is64;
  logic [3:0]          r_count;
  logic [63:0]         r_acc;
  logic [6:0]          r_shift;
  logic [63:0]         r_value;
  logic [ROM_ADDR-1:0] r_next_pc;
  logic [2:0]          r_trap;

  logic [63:0]         w_chunk;
  logic [63:0]         w_acc_nxt;
  logic [6:0]          w_shift_nxt;
  logic [3:0]          w_count_nxt;
  logic [3:0]          w_max;
  logic                w_term;
  logic                w_overrun;

  // Sign-extend from the first unfilled bit, then fold to the requested result width.
  function automatic logic [63:0] f_finalize(input logic [63:0] acc, input logic [6:0] shift,
                                             input logic sgn, input logic w64, input logic b6);
    logic [63:0] full;
    full = acc;
    if (sgn && b6 && (shift < 7'd64))
      full = acc | (~64'd0 << shift);
    if (w64)
      return full;
    else if (sgn)
      return {{32{full[31]}}, full[31:0]};
    else
      return {32'd0, full[31:0]};
  endfunction

  // Bits landing past bit 63 fall off the 64-bit shift, so they are dropped for free.
  assign w_chunk     = {57'd0, bus.rom_data[6:0]} << r_shift;
  assign w_acc_nxt   = r_acc | w_chunk;
  assign w_shift_nxt = r_shift + 7'd7;
  assign w_count_nxt = r_count + 4'd1;
  assign w_max       = r_is64 ? 4'd10 : 4'd5;
  assign w_term      = ~bus.rom_data[7];
  assign w_overrun   = bus.rom_data[7] && (w_count_nxt == w_max);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_WAIT;
      S_WAIT:  w_state_nxt = S_ACCUM;
      S_ACCUM: if (w_term || w_overrun) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_pc      <= '0;
      r_signed  <= 1'b0;
      r_is64    <= 1'b0;
      r_count   <= '0;
      r_acc     <= '0;
      r_shift   <= '0;
      r_value   <= '0;
      r_next_pc <= '0;
      r_trap    <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_addr   <= bus.pc_in;
            r_pc     <= bus.pc_in;
            r_signed <= bus.signed_mode;
            r_is64   <= bus.is_64;
            r_count  <= '0;
            r_acc    <= '0;
            r_shift  <= '0;
          end
        end
        S_WAIT: r_addr <= r_addr + ROM_ADDR'(1);
        S_ACCUM: begin
          r_acc   <= w_acc_nxt;
          r_shift <= w_shift_nxt;
          r_count <= w_count_nxt;
          r_addr  <= r_addr + ROM_ADDR'(1);
          // On overrun the consumed count equals the byte limit, so next_pc is the same sum.
          if (w_term) begin
            r_value   <= f_finalize(w_acc_nxt, w_shift_nxt, r_signed, r_is64, bus.rom_data[6]);
            r_next_pc <= r_pc + ROM_ADDR'(w_count_nxt);
            r_trap    <= 3'd0;
          end else if (w_overrun) begin
            r_value   <= '0;
            r_next_pc <= r_pc + ROM_ADDR'(w_count_nxt);
            r_trap    <= TRAP_MALFORMED;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rom_addr = r_addr;
  assign bus.busy     = (r_state == S_WAIT) || (r_state == S_ACCUM);
  assign bus.done     = (r_state == S_DONE);
  assign bus.value    = r_value;
  assign bus.next_pc  = r_next_pc;
  assign bus.trap     = r_trap;

endmodule

// File: tb/tb_leb128_decoder.sv
// Directed bench for leb128_decoder: registered-read ROM model plus per-scenario tasks.
module tb_leb128_decoder;

  logic clk;
  logic reset;
  logic [7:0] rom [16];
  int checks;
  int failures;

  leb128_decoder_if #(.ROM_ADDR(4)) bus ();

  leb128_decoder #(.ROM_ADDR(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  // Starts a decode and waits (bounded) for done; returns at the negedge where done is high.
  task automatic run_decode(input logic [3:0] pc, input logic s, input logic w,
                            output int lat, output bit timed_out, output bit busy_ok);
    int k;
    @(negedge clk);
    bus.pc_in = pc; bus.signed_mode = s; bus.is_64 = w; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    k = 1; timed_out = 1'b1; busy_ok = 1'b1;
    while (k < 30) begin
      if (bus.done) begin
        timed_out = 1'b0;
        if (bus.busy !== 1'b0) busy_ok = 1'b0;
        break;
      end
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      k++;
    end
    lat = k - 1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.rom_addr !== 4'd0 || bus.value !== 64'd0 ||
        bus.next_pc !== 4'd0 || bus.trap !== 3'd0) begin
      failures++;
      $display("FAIL reset_state got busy=%b done=%b addr=%h value=%h npc=%h trap=%h want all 0",
               bus.busy, bus.done, bus.rom_addr, bus.value, bus.next_pc, bus.trap);
    end
    reset = 1'b0;
  endtask

  task automatic test_single_byte();
    int lat; bit to; bit bok;
    rom[0] = 8'h05;
    run_decode(4'd0, 1'b0, 1'b0, lat, to, bok);
    checks++;
    if (to !== 1'b0 || lat !== 2) begin
      failures++; $display("FAIL single_latency got=%0d timeout=%b want=2", lat, to);
    end
    checks++;
    if (bus.value !== 64'd5 || bus.next_pc !== 4'd1 || bus.trap !== 3'd0) begin
      failures++;
      $display("FAIL single_result got value=%h npc=%0d trap=%0d want 5/1/0", bus.value, bus.next_pc, bus.trap);
    end
    checks++;
    if (bok !== 1'b1) begin
      failures++; $display("FAIL single_busy got=%b want=1", bok);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.value !== 64'd5) begin
      failures++; $display("FAIL single_pulse_hold got done=%b value=%h want 0/5", bus.done, bus.value);
    end
  endtask

  task automatic test_multi_byte();
    int lat; bit to; bit bok;
    rom[2] = 8'hE5; rom[3] = 8'h8E; rom[4] = 8'h26;
    run_decode(4'd2, 1'b0, 1'b1, lat, to, bok);
    checks++;
    if (to !== 1'b0 || lat !== 4) begin
      failures++; $display("FAIL multi_latency got=%0d timeout=%b want=4", lat, to);
    end
    checks++;
    if (bus.value !== 64'h98765 || bus.next_pc !== 4'd5 || bus.trap !== 3'd0 || bok !== 1'b1) begin
      failures++;
      $display("FAIL multi_result got value=%h npc=%0d trap=%0d busy_ok=%b want 98765/5/0/1",
               bus.value, bus.next_pc, bus.trap, bok);
    end
  endtask

  task automatic test_signed();
    int lat; bit to; bit bok;
    rom[0] = 8'h7F;
    run_decode(4'd0, 1'b1, 1'b1, lat, to, bok);
    checks++;
    if (to !== 1'b0 || bus.value !== 64'hFFFF_FFFF_FFFF_FFFF || bus.next_pc !== 4'd1) begin
      failures++; $display("FAIL signed_m1 got value=%h npc=%0d want all-ones/1", bus.value, bus.next_pc);
    end
    run_decode(4'd0, 1'b0, 1'b0, lat, to, bok);
    checks++;
    if (to !== 1'b0 || bus.value !== 64'h7F) begin
      failures++; $display("FAIL unsigned_7f got value=%h want 7f", bus.value);
    end
    rom[6] = 8'hC0; rom[7] = 8'hBB; rom[8] = 8'h78;
    run_decode(4'd6, 1'b1, 1'b1, lat, to, bok);
    checks++;
    if (to !== 1'b0 || bus.value !== 64'hFFFF_FFFF_FFFE_1DC0 || bus.next_pc !== 4'd9 || lat !== 4) begin
      failures++;
      $display("FAIL signed64_neg got value=%h npc=%0d lat=%0d want fffffffffffe1dc0/9/4", bus.value, bus.next_pc, lat);
    end
    run_decode(4'd6, 1'b1, 1'b0, lat, to, bok);
    checks++;
    if (to !== 1'b0 || bus.value !== 64'hFFFF_FFFF_FFFE_1DC0) begin
      failures++; $display("FAIL signed32_neg got value=%h want fffffffffffe1dc0", bus.value);
    end
    run_decode(4'd6, 1'b0, 1'b0, lat, to, bok);
    checks++;
    if (to !== 1'b0 || bus.value !== 64'h1E1DC0) begin
      failures++; $display("FAIL unsigned32_c0 got value=%h want 1e1dc0", bus.value);
    end
  endtask

  task automatic test_overrun();
    int lat; bit to; bit bok;
    for (int i = 0; i < 5; i++) rom[i] = 8'h80;
    rom[5] = 8'h01;
    run_decode(4'd0, 1'b0, 1'b0, lat, to, bok);
    checks++;
    if (to !== 1'b0 || bus.trap !== 3'd5 || bus.value !== 64'd0 || bus.next_pc !== 4'd5 || lat !== 6) begin
      failures++;
      $display("FAIL overrun32 got trap=%0d value=%h npc=%0d lat=%0d want 5/0/5/6", bus.trap, bus.value, bus.next_pc, lat);
    end
    run_decode(4'd0, 1'b0, 1'b1, lat, to, bok);
    checks++;
    if (to !== 1'b0 || bus.trap !== 3'd0 || bus.value !== 64'h8_0000_0000 || bus.next_pc !== 4'd6) begin
      failures++;
      $display("FAIL six_byte64 got trap=%0d value=%h npc=%0d want 0/800000000/6", bus.trap, bus.value, bus.next_pc);
    end
  endtask

  task automatic test_wrap();
    int lat; bit to; bit bok;
    rom[14] = 8'h81; rom[15] = 8'h80; rom[0] = 8'h01;
    run_decode(4'd14, 1'b0, 1'b0, lat, to, bok);
    checks++;
    if (to !== 1'b0 || bus.value !== 64'h4001 || bus.next_pc !== 4'd1 || bus.trap !== 3'd0) begin
      failures++; $display("FAIL addr_wrap got value=%h npc=%0d want 4001/1", bus.value, bus.next_pc);
    end
  endtask

  task automatic test_reset_abort();
    int lat; bit to; bit bok; bit seen;
    rom[2] = 8'hE5; rom[3] = 8'h8E; rom[4] = 8'h26;
    @(negedge clk);
    bus.pc_in = 4'd2; bus.signed_mode = 1'b0; bus.is_64 = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.rom_addr !== 4'd0 || bus.value !== 64'd0 ||
        bus.next_pc !== 4'd0 || bus.trap !== 3'd0) begin
      failures++;
      $display("FAIL abort_state got busy=%b done=%b addr=%h value=%h npc=%h trap=%h want all 0",
               bus.busy, bus.done, bus.rom_addr, bus.value, bus.next_pc, bus.trap);
    end
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++; $display("FAIL abort_no_done got activity=%b want 0", seen);
    end
    run_decode(4'd2, 1'b0, 1'b1, lat, to, bok);
    checks++;
    if (to !== 1'b0 || bus.value !== 64'h98765 || bus.next_pc !== 4'd5 || lat !== 4) begin
      failures++;
      $display("FAIL abort_restart got value=%h npc=%0d lat=%0d want 98765/5/4", bus.value, bus.next_pc, lat);
    end
  endtask

  task automatic test_start_ignored();
    int k; bit to;
    rom[0] = 8'h7F;
    rom[2] = 8'hE5; rom[3] = 8'h8E; rom[4] = 8'h26;
    @(negedge clk);
    bus.pc_in = 4'd2; bus.signed_mode = 1'b0; bus.is_64 = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.pc_in = 4'd0; bus.signed_mode = 1'b1; bus.is_64 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    k = 3; to = 1'b1;
    while (k < 30) begin
      if (bus.done) begin to = 1'b0; break; end
      @(negedge clk);
      k++;
    end
    checks++;
    if (to !== 1'b0 || k - 1 !== 4 || bus.value !== 64'h98765 || bus.next_pc !== 4'd5 || bus.trap !== 3'd0) begin
      failures++;
      $display("FAIL start_ignored got value=%h npc=%0d lat=%0d timeout=%b want 98765/5/4/0",
               bus.value, bus.next_pc, k - 1, to);
    end
  endtask

  task automatic test_back_to_back();
    int lat; bit to; bit bok;
    rom[0] = 8'h05;
    rom[2] = 8'hE5; rom[3] = 8'h8E; rom[4] = 8'h26;
    run_decode(4'd0, 1'b0, 1'b0, lat, to, bok);
    checks++;
    if (to !== 1'b0 || bus.value !== 64'd5 || lat !== 2) begin
      failures++; $display("FAIL b2b_first got value=%h lat=%0d want 5/2", bus.value, lat);
    end
    run_decode(4'd2, 1'b0, 1'b1, lat, to, bok);
    checks++;
    if (to !== 1'b0 || bus.value !== 64'h98765 || bus.next_pc !== 4'd5 || lat !== 4 || bok !== 1'b1) begin
      failures++;
      $display("FAIL b2b_second got value=%h npc=%0d lat=%0d busy_ok=%b want 98765/5/4/1",
               bus.value, bus.next_pc, lat, bok);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    bus.start = 1'b0; bus.pc_in = 4'd0; bus.signed_mode = 1'b0; bus.is_64 = 1'b0;
    reset = 1'b1;
    test_reset();
    test_single_byte();
    test_multi_byte();
    test_signed();
    test_overrun();
    test_wrap();
    test_reset_abort();
    test_start_ignored();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
